register_file: RTL and testbench

- General-purpose 2-read / 1-write register file: 32 entries of 32 bits, with register 0 hardwired to zero.
- Sits in the CPU datapath between decode and execute.
- Supplies operands A and B from registered outputs and accepts one write-back per cycle.
- All operations are gated by a global enable.

---
 rtl/register_file_if.sv | 45 ++++
 rtl/register_file.sv | 117 +++++++++++
 tb/tb_register_file.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Bundles the access signals of the 2-read / 1-write register
//               file. The master drives the enable, select indices, strobes
//               and write data. The slave (the register file) returns the two
//               registered operands.
//   EN        global enable; gates every read and write
//   selectW1  write index
//   selectR1  read port A index
//   selectR2  read port B index
//   read      read strobe; captures both ports
//   write     write strobe
//   addr      write data (the name is historical; it carries data)
//   outA      registered operand A
//   outB      registered operand B
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              EN;
    logic [ADDR_W-1:0] selectW1;
    logic [ADDR_W-1:0] selectR1;
    logic [ADDR_W-1:0] selectR2;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;

    modport master (
        output EN, selectW1, selectR1, selectR2, read, write, addr,
        input  outA, outB
    );

    modport slave (
        input  EN, selectW1, selectR1, selectR2, read, write, addr,
        output outA, outB
    );

endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : General-purpose register file with 2**ADDR_W entries of
//               DATA_W bits, two registered read ports and one write port.
//               Entry 0 is hardwired to zero and has no storage behind it.
//               All accesses are gated by the global enable EN.
// Ports       :
//   clk   system clock; all state changes on the rising edge
//   rst   synchronous, active-high reset; clears the array and both outputs
//   rf    register_file_if.slave: EN, selectW1/R1/R2, read, write, addr in;
//         outA, outB out
// Build option: REGISTER_FILE_BYPASS_EN
//   defined   - write-to-read forwarding: a read that hits the index being
//               written in the same cycle returns the new data
//   undefined - read-before-write: the same-cycle read returns old contents
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    register_file_if.slave      rf
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage starts at index 1; index 0 is a constant zero.
    logic [DATA_W-1:0] mem_q [1:DEPTH-1];
    logic [DATA_W-1:0] mem_d [1:DEPTH-1];

    logic [DATA_W-1:0] outA_q, outA_d;
    logic [DATA_W-1:0] outB_q, outB_d;

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_a_old;
    logic [DATA_W-1:0] rd_b_old;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // A write to index 0 is dropped here, which also keeps it out of the
    // forwarding path below.
    assign wr_en = rf.EN & rf.write & (rf.selectW1 != '0);
    assign rd_en = rf.EN & rf.read;

    // ------------------------------------------------------------------
    // Array read (contents before this cycle's write)
    // ------------------------------------------------------------------
    always_comb begin
        rd_a_old = '0;
        rd_b_old = '0;
        if (rf.selectR1 != '0) begin
            rd_a_old = mem_q[rf.selectR1];
        end
        if (rf.selectR2 != '0) begin
            rd_b_old = mem_q[rf.selectR2];
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // wr_en already excludes index 0, so a hit here is always on real storage.
    assign fwd_a = wr_en & (rf.selectR1 == rf.selectW1);
    assign fwd_b = wr_en & (rf.selectR2 == rf.selectW1);
    assign rd_a  = fwd_a ? rf.addr : rd_a_old;
    assign rd_b  = fwd_b ? rf.addr : rd_b_old;
`else
    assign rd_a  = rd_a_old;
    assign rd_b  = rd_b_old;
`endif

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[rf.selectW1] = rf.addr;
        end
    end

    always_comb begin
        outA_d = outA_q;
        outB_d = outB_q;
        if (rd_en) begin
            outA_d = rd_a;
            outB_d = rd_b;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            outA_q <= '0;
            outB_q <= '0;
        end else begin
            mem_q  <= mem_d;
            outA_q <= outA_d;
            outB_q <= outB_d;
        end
    end

    assign rf.outA = outA_q;
    assign rf.outB = outB_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file. A driver applies one
//               access per cycle, updates a behavioural array model and
//               queues the operands expected after the coming edge. A
//               separate monitor pops each expectation after the edge and
//               compares it with outA/outB. Directed cases are followed by
//               randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        string             tag;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain array of 32 words plus the last captured operands.
    logic [DATA_W-1:0] mdl [32];
    logic [DATA_W-1:0] exp_a = '0;
    logic [DATA_W-1:0] exp_b = '0;

    function automatic logic [DATA_W-1:0] model_read(input int idx, input bit wr_hit,
                                                     input logic [DATA_W-1:0] wdata);
        if (idx == 0) return '0;
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_hit) return wdata;
`endif
        return mdl[idx];
    endfunction

    // Apply one cycle of stimulus, advance the model and queue the expectation.
    task automatic step(input logic r, input logic en, input logic wr,
                        input logic [ADDR_W-1:0] sw, input logic [DATA_W-1:0] d,
                        input logic rd, input logic [ADDR_W-1:0] s1,
                        input logic [ADDR_W-1:0] s2, input string tag);
        exp_t e;
        bit   wq;
        rst         = r;
        rf.EN       = en;
        rf.write    = wr;
        rf.selectW1 = sw;
        rf.addr     = d;
        rf.read     = rd;
        rf.selectR1 = s1;
        rf.selectR2 = s2;

        if (r) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
            exp_a = '0;
            exp_b = '0;
        end else if (en) begin
            wq = wr && (sw != 0);
            if (rd) begin
                exp_a = model_read(int'(s1), wq && (s1 == sw), d);
                exp_b = model_read(int'(s2), wq && (s2 == sw), d);
            end
            if (wq) mdl[sw] = d;
        end
        e.a   = exp_a;
        e.b   = exp_b;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are valid one edge after every driven cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (rf.outA !== e.a || rf.outB !== e.b) begin
                    n_bad++;
                    $display("FAIL %s: outA=%0d outB=%0d, required outA=%0d outB=%0d",
                             e.tag, rf.outA, rf.outB, e.a, e.b);
                end
            end
        end
    end

    initial begin : driver
        logic [ADDR_W-1:0] sw, s1, s2;
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        // Reset hold; strobes during reset must be ignored.
        for (int i = 0; i < 5; i++) step(1, 1, 1, 5'd1, 32'hFFFF, 1, 5'd1, 5'd2, "reset");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd1, 5'd2, "reset_read");

        // Write then read
        step(0, 1, 1, 5'd1, 32'd123, 0, 5'd0, 5'd0, "wr1");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd1, 5'd2, "rd_after_wr1");
        step(0, 1, 0, 5'd0, 32'd0, 0, 5'd4, 5'd4, "hold_no_read");

        // Second write
        step(0, 1, 1, 5'd3, 32'd456, 0, 5'd0, 5'd0, "wr3");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd3, 5'd1, "rd_3_1");

        // Register 0 protection
        step(0, 1, 1, 5'd0, 32'd123, 0, 5'd0, 5'd0, "wr0");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, "rd0");
        step(0, 1, 1, 5'd0, 32'd99, 1, 5'd0, 5'd0, "wr0_rd0_same_cycle");

        // Enable gating
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd3, 5'd1, "reload");
        step(0, 0, 1, 5'd2, 32'd77, 1, 5'd2, 5'd2, "en0_write");
        step(0, 0, 0, 5'd0, 32'd0, 1, 5'd2, 5'd2, "en0_read_hold");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd2, 5'd2, "rd2_after_gated_wr");

        // Same-cycle hazard and identical ports
        step(0, 1, 1, 5'd5, 32'd9, 0, 5'd0, 5'd0, "wr5_9");
        step(0, 1, 1, 5'd5, 32'd10, 1, 5'd5, 5'd5, "hazard");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd5, 5'd0, "hazard_next");

        // Reset aborts a pending write and clears earlier data
        step(1, 1, 1, 5'd7, 32'd55, 1, 5'd7, 5'd3, "mid_reset");
        step(0, 1, 0, 5'd0, 32'd0, 1, 5'd7, 5'd3, "after_mid_reset");

        // Randomized traffic; half the indices come from a small range so
        // write/read collisions happen often.
        for (int i = 0; i < 400; i++) begin
            sw = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 1)),
                 sw, $urandom(),
                 1'($urandom_range(0, 1)),
                 s1, s2, "random");
        end
        step(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, "final_hold");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
